// File: rtl/tcam_pkg.sv
// Shared types and the ternary compare helper for the TCAM lookup core.
package tcam_pkg;

  localparam int TCAM_W = 32;

  typedef struct packed {
    logic              valid;
    logic [TCAM_W-1:0] value;
    logic [TCAM_W-1:0] mask;
  } entry_t;

  // A bit is don't-care when set in either the stored mask or the key mask.
  function automatic logic tcam_bit_match(input logic [TCAM_W-1:0] value,
                                          input logic [TCAM_W-1:0] mask,
                                          input logic [TCAM_W-1:0] key,
                                          input logic [TCAM_W-1:0] kmask);
    return ((value ^ key) & ~mask & ~kmask) == '0;
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the match vector wins.
module tcam_prio_enc #(
  parameter int TCAM_DEPTH = 16,
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH)
) (
  input  logic [TCAM_DEPTH-1:0]       match_i,
  output logic                        hit_o,
  output logic [TCAM_INDEX_WIDTH-1:0] idx_o
);

  always_comb begin
    hit_o = |match_i;
    idx_o = '0;
    for (int e = TCAM_DEPTH - 1; e >= 0; e--) begin
      if (match_i[e]) idx_o = TCAM_INDEX_WIDTH'(e);
    end
  end

endmodule

// File: rtl/tcam_core.sv
// Ternary CAM core: indexed writes, parallel search with a one-cycle registered result.
module tcam_core
  import tcam_pkg::*;
#(
  parameter int TCAM_WIDTH = TCAM_W,
  parameter int TCAM_DEPTH = 16,
  localparam int TCAM_INDEX_WIDTH = $clog2(TCAM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_we,
  input  logic [TCAM_INDEX_WIDTH-1:0] data_idx,
  input  logic [TCAM_WIDTH-1:0]       data_i,
  input  logic [TCAM_WIDTH-1:0]       data_mask,
  output logic                        index_rdy,
  output logic [TCAM_INDEX_WIDTH-1:0] index_o
);

  entry_t                        entry_q [TCAM_DEPTH];
  entry_t                        entry_d [TCAM_DEPTH];
  logic [TCAM_DEPTH-1:0]         match;
  logic                          enc_hit;
  logic [TCAM_INDEX_WIDTH-1:0]   enc_idx;
  logic                          index_rdy_q, index_rdy_d;
  logic [TCAM_INDEX_WIDTH-1:0]   index_o_q, index_o_d;

  // Index decode by equality, so out-of-range indices on non-power-of-2 depths write nothing.
  always_comb begin
    for (int e = 0; e < TCAM_DEPTH; e++) begin
      entry_d[e] = entry_q[e];
      if (data_we && (data_idx == TCAM_INDEX_WIDTH'(e))) begin
        entry_d[e].valid = 1'b1;
        entry_d[e].value = data_i;
        entry_d[e].mask  = data_mask;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < TCAM_DEPTH; e++) begin
      match[e] = entry_q[e].valid &&
                 tcam_bit_match(entry_q[e].value, entry_q[e].mask, data_i, data_mask);
    end
  end

  tcam_prio_enc #(
    .TCAM_DEPTH (TCAM_DEPTH)
  ) u_prio_enc (
    .match_i (match),
    .hit_o   (enc_hit),
    .idx_o   (enc_idx)
  );

  always_comb begin
    index_rdy_d = ~data_we & enc_hit;
    index_o_d   = index_rdy_d ? enc_idx : index_o_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < TCAM_DEPTH; e++) entry_q[e] <= '0;
      index_rdy_q <= 1'b0;
      index_o_q   <= '0;
    end else begin
      for (int e = 0; e < TCAM_DEPTH; e++) entry_q[e] <= entry_d[e];
      index_rdy_q <= index_rdy_d;
      index_o_q   <= index_o_d;
    end
  end

  assign index_rdy = index_rdy_q;
  assign index_o   = index_o_q;

endmodule

// File: tb/tb_tcam_core.sv
// Directed bench for tcam_core: inputs driven at negedge, outputs sampled at the next negedge.
module tb_tcam_core;

  logic        clk;
  logic        rst;
  logic        data_we;
  logic [3:0]  data_idx;
  logic [31:0] data_i;
  logic [31:0] data_mask;
  logic        index_rdy;
  logic [3:0]  index_o;

  int n_total;
  int n_pass;

  tcam_core #(
    .TCAM_WIDTH (32),
    .TCAM_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_we   (data_we),
    .data_idx  (data_idx),
    .data_i    (data_i),
    .data_mask (data_mask),
    .index_rdy (index_rdy),
    .index_o   (index_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] val, input logic [31:0] msk);
    data_we   = 1'b1;
    data_idx  = idx;
    data_i    = val;
    data_mask = msk;
    @(negedge clk);
  endtask

  task automatic do_search(input string tag, input logic [31:0] key, input logic [31:0] kmsk,
                           input logic exp_rdy, input logic [3:0] exp_idx);
    data_we   = 1'b0;
    data_idx  = 4'd0;
    data_i    = key;
    data_mask = kmsk;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, index_rdy}, {31'd0, exp_rdy});
    check({tag, "_idx"}, {28'd0, index_o}, {28'd0, exp_idx});
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    data_we   = 1'b0;
    data_idx  = 4'd0;
    data_i    = 32'd0;
    data_mask = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_rdy", {31'd0, index_rdy}, 32'd0);
    check("reset_idx", {28'd0, index_o}, 32'd0);
    rst = 1'b0;

    // 1. empty table
    do_search("empty", 32'h0000_0000, 32'h0, 1'b0, 4'd0);

    // 2. exact match
    do_write(4'd3, 32'h1234_5678, 32'h0);
    check("write_rdy_low", {31'd0, index_rdy}, 32'd0);
    do_search("exact_hit", 32'h1234_5678, 32'h0, 1'b1, 4'd3);
    do_search("exact_miss", 32'h1234_5679, 32'h0, 1'b0, 4'd3);

    // 3. stored mask
    do_write(4'd5, 32'hABCD_0000, 32'h0000_FFFF);
    do_search("smask_hit", 32'hABCD_1234, 32'h0, 1'b1, 4'd5);
    do_search("smask_miss", 32'hABCE_1234, 32'h0, 1'b0, 4'd5);

    // 4. priority and overwrite
    do_write(4'd2, 32'hDEAD_BEEF, 32'h0);
    do_write(4'd9, 32'hDEAD_BEEF, 32'h0);
    do_search("prio_low", 32'hDEAD_BEEF, 32'h0, 1'b1, 4'd2);
    do_write(4'd2, 32'h0000_0000, 32'h0);
    check("write_hold_idx", {28'd0, index_o}, 32'd2);
    do_search("prio_overwrite", 32'hDEAD_BEEF, 32'h0, 1'b1, 4'd9);

    // 5. key mask
    do_write(4'd1, 32'h0000_000F, 32'h0);
    do_write(4'd4, 32'h0000_00FF, 32'h0);
    do_search("kmask_hit", 32'h0000_00F0, 32'h0000_000F, 1'b1, 4'd4);
    do_search("kmask_all", 32'h5555_AAAA, 32'hFFFF_FFFF, 1'b1, 4'd1);
    do_write(4'd0, 32'h1357_9BDF, 32'hFFFF_FFFF);
    do_search("full_mask_entry", 32'hCAFE_F00D, 32'h0, 1'b1, 4'd0);
    do_search("back_to_back", 32'h0000_00FF, 32'h0, 1'b1, 4'd0);

    // 6. clean table, then alternate write/search with a mid-stream async reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_search("cleared", 32'hDEAD_BEEF, 32'h0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      do_write(4'(i), 32'h0101_0101 * (i + 1), 32'h0);
      do_search("alt", 32'h0101_0101 * (i + 1), 32'h0, 1'b1, 4'(i));
    end
    do_write(4'd8, 32'h0909_0909, 32'h0);
    data_we   = 1'b0;
    data_i    = 32'h0909_0909;
    data_mask = 32'h0;
    @(posedge clk);
    #1;
    check("inflight_rdy", {31'd0, index_rdy}, 32'd1);
    check("inflight_idx", {28'd0, index_o}, 32'd8);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rdy", {31'd0, index_rdy}, 32'd0);
    check("async_rst_idx", {28'd0, index_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_search("post_rst", 32'h0101_0101 * (i + 1), 32'h0, 1'b0, 4'd0);
    end
    do_search("post_rst_kmask", 32'h0, 32'hFFFF_FFFF, 1'b0, 4'd0);
    do_write(4'd6, 32'h0707_0707, 32'h0);
    do_search("rewrite", 32'h0707_0707, 32'h0, 1'b1, 4'd6);
    do_search("rewrite_kmask", 32'h0, 32'hFFFF_FFFF, 1'b1, 4'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
